rgb_sram_writer: RTL and testbench

- Write-side counterpart to the VGA display path: accepts a stream of 24-bit RGB pixels and stores them in external SRAM.
- Uses the same packed layout the VGA reader consumes: 2 pixels per 3 consecutive 16-bit words, starting at a programmable base address.
- Sits at the output of the colour-space-conversion stage, so the VGA block can display the decoded image directly.

---
 rtl/rgb_sram_writer.sv | 135 +++++++++++++
 tb/tb_rgb_sram_writer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_sram_writer.sv
// Packs a stream of 24-bit RGB pixels into SRAM, two pixels per three 16-bit words,
// in the same layout the VGA reader expects.
`timescale 1ns/1ps
module rgb_sram_writer #(
  parameter int NUM_PIXELS = 76800
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Start,
  input  logic [17:0] SRAM_base_address,
  input  logic        pixel_valid,
  output logic        pixel_ready,
  input  logic [7:0]  pixel_R,
  input  logic [7:0]  pixel_G,
  input  logic [7:0]  pixel_B,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  output logic        Busy,
  output logic        Done
);

  localparam int NUM_PAIRS = NUM_PIXELS / 2;
  localparam int CW        = $clog2(NUM_PAIRS + 1);

  typedef enum logic [1:0] {S_IDLE, S_EVEN, S_ODD, S_FLUSH} state_t;

  state_t      state, state_n;
  logic [17:0] wr_ptr, wr_ptr_n;
  logic [CW-1:0] pair_cnt, pair_cnt_n, pair_cnt_inc;
  logic [7:0]  hold_b0, hold_b0_n;
  logic [7:0]  hold_g1, hold_g1_n;
  logic [7:0]  hold_b1, hold_b1_n;
  logic [17:0] address_n;
  logic [15:0] write_data_n;
  logic        we_n_n, busy_n, done_n;
  logic        transfer;

  assign pixel_ready  = (state == S_EVEN) || (state == S_ODD);
  assign transfer     = pixel_valid && pixel_ready;
  assign pair_cnt_inc = pair_cnt + 1'b1;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_n      = state;
    wr_ptr_n     = wr_ptr;
    pair_cnt_n   = pair_cnt;
    hold_b0_n    = hold_b0;
    hold_g1_n    = hold_g1;
    hold_b1_n    = hold_b1;
    address_n    = SRAM_address;
    write_data_n = SRAM_write_data;
    we_n_n       = 1'b1;
    busy_n       = Busy;
    done_n       = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (Start) begin
          wr_ptr_n   = SRAM_base_address;
          pair_cnt_n = '0;
          busy_n     = 1'b1;
          state_n    = S_EVEN;
        end
      end
      S_EVEN: begin
        if (transfer) begin
          address_n    = wr_ptr;
          write_data_n = {pixel_R, pixel_G};
          we_n_n       = 1'b0;
          wr_ptr_n     = wr_ptr + 18'd1;
          hold_b0_n    = pixel_B;
          state_n      = S_ODD;
        end
      end
      S_ODD: begin
        // B0 waits in hold_b0 for as long as the odd pixel takes to arrive.
        if (transfer) begin
          address_n    = wr_ptr;
          write_data_n = {hold_b0, pixel_R};
          we_n_n       = 1'b0;
          wr_ptr_n     = wr_ptr + 18'd1;
          hold_g1_n    = pixel_G;
          hold_b1_n    = pixel_B;
          state_n      = S_FLUSH;
        end
      end
      S_FLUSH: begin
        address_n    = wr_ptr;
        write_data_n = {hold_g1, hold_b1};
        we_n_n       = 1'b0;
        wr_ptr_n     = wr_ptr + 18'd1;
        pair_cnt_n   = pair_cnt_inc;
        if (pair_cnt_inc == CW'(NUM_PAIRS)) begin
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = S_IDLE;
        end else begin
          state_n = S_EVEN;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state           <= S_IDLE;
      wr_ptr          <= '0;
      pair_cnt        <= '0;
      hold_b0         <= '0;
      hold_g1         <= '0;
      hold_b1         <= '0;
      SRAM_address    <= '0;
      SRAM_write_data <= '0;
      SRAM_we_n       <= 1'b1;
      Busy            <= 1'b0;
      Done            <= 1'b0;
    end else begin
      state           <= state_n;
      wr_ptr          <= wr_ptr_n;
      pair_cnt        <= pair_cnt_n;
      hold_b0         <= hold_b0_n;
      hold_g1         <= hold_g1_n;
      hold_b1         <= hold_b1_n;
      SRAM_address    <= address_n;
      SRAM_write_data <= write_data_n;
      SRAM_we_n       <= we_n_n;
      Busy            <= busy_n;
      Done            <= done_n;
    end
  end

endmodule

// File: tb/tb_rgb_sram_writer.sv
// Bench for rgb_sram_writer: a frame-level packing model feeds an expected-write queue per
// instance (4-pixel and 2-pixel frames), checked every cycle, plus directed checks.
`timescale 1ns/1ps
module tb_rgb_sram_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start [2];
  logic        valid [2];
  logic        ready [2];
  logic        we_n  [2];
  logic        busy  [2];
  logic        done  [2];
  logic [17:0] base  [2];
  logic [17:0] addr  [2];
  logic [15:0] wdata [2];
  logic [7:0]  r [2];
  logic [7:0]  g [2];
  logic [7:0]  b [2];

  typedef struct packed {
    logic [17:0] a;
    logic [15:0] d;
    logic        last;
  } wr_t;

  wr_t         q0[$];
  wr_t         q1[$];
  logic [23:0] pix[$];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  rgb_sram_writer #(.NUM_PIXELS(4)) u_dut4 (
    .Clock(clk), .Resetn(rst_n), .Start(start[0]), .SRAM_base_address(base[0]),
    .pixel_valid(valid[0]), .pixel_ready(ready[0]),
    .pixel_R(r[0]), .pixel_G(g[0]), .pixel_B(b[0]),
    .SRAM_address(addr[0]), .SRAM_write_data(wdata[0]), .SRAM_we_n(we_n[0]),
    .Busy(busy[0]), .Done(done[0])
  );

  rgb_sram_writer #(.NUM_PIXELS(2)) u_dut2 (
    .Clock(clk), .Resetn(rst_n), .Start(start[1]), .SRAM_base_address(base[1]),
    .pixel_valid(valid[1]), .pixel_ready(ready[1]),
    .pixel_R(r[1]), .pixel_G(g[1]), .pixel_B(b[1]),
    .SRAM_address(addr[1]), .SRAM_write_data(wdata[1]), .SRAM_we_n(we_n[1]),
    .Busy(busy[1]), .Done(done[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s", name);
  endtask

  // Frame model: each pixel pair is 48 bits {p0,p1} cut into three 16-bit words at
  // consecutive addresses (mod 2^18) from the base.
  task automatic model_frame(input int inst, input logic [17:0] bs);
    wr_t         w;
    logic [47:0] pair;
    for (int p = 0; p + 1 < pix.size(); p += 2) begin
      pair = {pix[p], pix[p+1]};
      for (int k = 0; k < 3; k++) begin
        w.a    = bs + 18'(3 * (p / 2) + k);
        w.d    = pair[47 - 16*k -: 16];
        w.last = (p + 2 == pix.size()) && (k == 2);
        if (inst == 0) q0.push_back(w);
        else           q1.push_back(w);
      end
    end
  endtask

  task automatic cmp_inst(input int i);
    wr_t e;
    int  sz;
    sz = (i == 0) ? q0.size() : q1.size();
    if (we_n[i] === 1'b0) begin
      if (sz == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write[%0d]: addr 0x%0h data 0x%0h, expected no write", i, addr[i], wdata[i]);
      end else begin
        if (i == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        check($sformatf("wr_addr[%0d]", i), 32'(addr[i]), 32'(e.a));
        check($sformatf("wr_data[%0d]@%0h", i, e.a), 32'(wdata[i]), 32'(e.d));
        check($sformatf("wr_done[%0d]@%0h", i, e.a), 32'(done[i]), 32'(e.last));
        check($sformatf("wr_busy[%0d]@%0h", i, e.a), 32'(busy[i]), 32'(!e.last));
      end
    end else begin
      check($sformatf("done_without_write[%0d]", i), 32'(done[i]), 32'd0);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) cmp_inst(i);
  end

  task automatic do_start(input int inst, input logic [17:0] bs);
    model_frame(inst, bs);
    base[inst]  = bs;
    start[inst] = 1'b1;
    @(negedge clk);
    start[inst] = 1'b0;
    check($sformatf("busy_after_start[%0d]", inst), 32'(busy[inst]), 32'd1);
  endtask

  // Offer one pixel and return at the first negedge after it has been taken.
  task automatic push_px(input int inst, input logic [23:0] px);
    int n = 0;
    {r[inst], g[inst], b[inst]} = px;
    valid[inst] = 1'b1;
    while (ready[inst] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) fail_now($sformatf("push_timeout[%0d]", inst));
    @(negedge clk);
    valid[inst] = 1'b0;
  endtask

  task automatic idle(input int inst, input int n);
    valid[inst] = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(input int inst);
    int n = 0;
    while (done[inst] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n == 100) fail_now($sformatf("done_timeout[%0d]", inst));
    @(negedge clk);
    check($sformatf("done_one_cycle[%0d]", inst), 32'(done[inst]), 32'd0);
    check($sformatf("busy_after_done[%0d]", inst), 32'(busy[inst]), 32'd0);
    check($sformatf("we_n_after_done[%0d]", inst), 32'(we_n[inst]), 32'd1);
    check($sformatf("queue_drained[%0d]", inst), (inst == 0) ? q0.size() : q1.size(), 32'd0);
  endtask

  task automatic load_std_pixels();
    pix = '{24'h112233, 24'h445566, 24'h778899, 24'hAABBCC};
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       rdy;
    logic [2:0] exp_ready;
    int         idx;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; valid[i] = 1'b0; base[i] = '0;
      r[i] = '0; g[i] = '0; b[i] = '0;
    end

    // Reset state and quiet idle.
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_we_n[%0d]", i),  32'(we_n[i]),  32'd1);
      check($sformatf("rst_busy[%0d]", i),  32'(busy[i]),  32'd0);
      check($sformatf("rst_done[%0d]", i),  32'(done[i]),  32'd0);
      check($sformatf("rst_ready[%0d]", i), 32'(ready[i]), 32'd0);
      check($sformatf("rst_addr[%0d]", i),  32'(addr[i]),  32'd0);
      check($sformatf("rst_data[%0d]", i),  32'(wdata[i]), 32'd0);
    end
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("idle_ready", 32'(ready[0]), 32'd0);
    check("idle_busy",  32'(busy[0]),  32'd0);

    // Continuous stream, NUM_PIXELS=4, base 0x100, with the ready pattern 1,1,0,1,1,0.
    load_std_pixels();
    do_start(0, 18'h00100);
    check("model_a0", 32'(q0[0].a), 32'h00100);
    check("model_d0", 32'(q0[0].d), 32'h1122);
    check("model_d1", 32'(q0[1].d), 32'h3344);
    check("model_d4", 32'(q0[4].d), 32'h99AA);
    check("model_a5", 32'(q0[5].a), 32'h00105);
    check("model_d5", 32'(q0[5].d), 32'hBBCC);
    check("model_last5", 32'(q0[5].last), 32'd1);
    exp_ready = 3'b011;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      if (idx < pix.size()) {r[0], g[0], b[0]} = pix[idx];
      valid[0] = 1'b1;
      rdy = ready[0];
      check($sformatf("ready_pattern_c%0d", c), 32'(rdy), 32'(exp_ready[c % 3]));
      @(negedge clk);
      if (rdy) idx++;
    end
    valid[0] = 1'b0;
    check("stream_pixels_taken", idx, 32'd4);
    wait_done(0);

    // Same data with gaps after p0 and p1.
    do_start(0, 18'h00100);
    push_px(0, pix[0]);
    idle(0, 3);
    push_px(0, pix[1]);
    idle(0, 2);
    push_px(0, pix[2]);
    push_px(0, pix[3]);
    wait_done(0);

    // Start mid-frame is ignored; a later frame begins at the new base.
    do_start(0, 18'h00100);
    push_px(0, pix[0]);
    base[0]  = 18'h0FFFF;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    for (int p = 1; p < 4; p++) push_px(0, pix[p]);
    wait_done(0);
    pix = '{24'h0A0B0C, 24'h0D0E0F, 24'h102030, 24'h405060};
    do_start(0, 18'h20000);
    check("model_new_base", 32'(q0[0].a), 32'h20000);
    for (int p = 0; p < 4; p++) push_px(0, pix[p]);
    wait_done(0);

    // NUM_PIXELS=2 across the top of the address space.
    pix = '{24'h010203, 24'h040506};
    do_start(1, 18'h3FFFE);
    check("model_wrap_a0", 32'(q1[0].a), 32'h3FFFE);
    check("model_wrap_d0", 32'(q1[0].d), 32'h0102);
    check("model_wrap_d1", 32'(q1[1].d), 32'h0304);
    check("model_wrap_a2", 32'(q1[2].a), 32'h00000);
    check("model_wrap_d2", 32'(q1[2].d), 32'h0506);
    push_px(1, pix[0]);
    push_px(1, pix[1]);
    wait_done(1);

    // Reset while waiting for the odd pixel abandons the frame.
    load_std_pixels();
    do_start(0, 18'h00100);
    push_px(0, pix[0]);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_we_n",  32'(we_n[0]),  32'd1);
    check("midrst_addr",  32'(addr[0]),  32'd0);
    check("midrst_data",  32'(wdata[0]), 32'd0);
    check("midrst_busy",  32'(busy[0]),  32'd0);
    check("midrst_done",  32'(done[0]),  32'd0);
    check("midrst_ready", 32'(ready[0]), 32'd0);
    q0.delete();
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    do_start(0, 18'h00200);
    for (int p = 0; p < 4; p++) push_px(0, pix[p]);
    wait_done(0);

    repeat (5) @(negedge clk);
    check("final_q0_empty", q0.size(), 32'd0);
    check("final_q1_empty", q1.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
